armleocpu_axi_fifo_slice: RTL and testbench
===========================================

# armleocpu_axi_fifo_slice

Parametrised AXI4 channel buffer between an AXI host (upstream) and an AXI client (downstream). Each of the five channels (AW, W, B, AR, R) has its own independently sized buffer: combinational passthrough, a single register, or a power-of-two FIFO. An aggregate `idle` status supports clock-gating and drain checks. It sits at interconnect boundaries that need more decoupling than a single register stage.

## Interface
- ADDR_WIDTH, 32, AW/AR address width
- DATA_WIDTH, 32, W/R data width; strobes = DATA_WIDTH/8
- ID_WIDTH, 4, AXI ID width on all channels
- AW_DEPTH, 2, AW buffer entries: 0, 1, or a power of two ≥ 2
- W_DEPTH, 2, W buffer entries, same rule
- B_DEPTH, 2, B buffer entries, same rule
- AR_DEPTH, 2, AR buffer entries, same rule
- R_DEPTH, 2, R buffer entries, same rule

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- upstream_axi_aw{valid,ready,addr,len,size,burst,lock,id,prot}  client  1/1/ADDR_WIDTH/8/3/2/1/ID_WIDTH/3  AW from host
- upstream_axi_w{valid,ready,data,strb,last}  client  1/1/DATA_WIDTH/DATA_WIDTH/8/1  W from host
- upstream_axi_b{valid,ready,resp,id}  client  1/1/2/ID_WIDTH  B to host
- upstream_axi_ar{…}  client  same as AW  AR from host
- upstream_axi_r{valid,ready,resp,data,last,id}  client  1/1/2/DATA_WIDTH/1/ID_WIDTH  R to host
- downstream_axi_{aw,w,b,ar,r}*  host  same widths, mirrored directions  to/from client
- idle  out  1  high when every buffered channel holds zero entries

## Operation
- Payload per channel: AW/AR {addr,len,size,burst,lock,id,prot}; W {data,strb,last}; B {id,resp}; R {id,resp,data,last}. Payload is carried bit-exact and in order, with no reordering, merging or dropping.
- Forward channels (AW, W, AR) push from upstream and pop to downstream. Reverse channels (B, R) push from downstream and pop to upstream.
- DEPTH=0: wires only. out_valid=in_valid, in_ready=out_ready, out_data=in_data. The channel contributes nothing to `idle`.
- DEPTH=1: one-entry register with a full flag. in_ready=!full. Push sets full. Pop clears it. Push and pop never occur in the same cycle. Maximum throughput is 1 beat per 2 cycles.
- DEPTH=D≥2: circular buffer with wr_ptr and rd_ptr of width log2(D), wrapping D-1→0.
  - count width is log2(D)+1. in_ready=(count!=D). out_valid=(count!=0).
  - push = in_valid&&in_ready. pop = out_valid&&out_ready.
  - Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any count except D (no push) and 0 (no pop).
  - Full throughput is 1 beat per cycle.
- No fall-through. An entry pushed into an empty buffer is not visible at the output in the same cycle.
- out_data is driven from the storage entry at rd_ptr and stays stable while out_valid is high and out_ready is low.
- idle = AND over buffered channels of (count==0). It is registered-count based with no combinational path from valid inputs.
- rst_n low:
  - All counts, pointers and full flags are cleared.
  - in_ready is forced to 0 for DEPTH≥1.
  - Handshakes in that cycle are ignored.
  - Storage contents are not reset.

## Timing
- Reset values, DEPTH≥1:
  - all out_valid = 0.
  - all in_ready = 0 while rst_n is low, and 1 in the first cycle after release.
  - idle = 1.
  - data outputs are don't-care.
- Latency, DEPTH≥1: a beat accepted at edge N is presented with out_valid=1 from edge N to edge N+1. Minimum latency is 1 cycle.
- in_ready depends only on registered state, never combinationally on out_ready. out_valid depends only on registered state.
- Reset mid-operation: all buffered beats are discarded, and out_valid falls after the reset edge. The requirement to reset both AXI sides together is owned by the system integrator.
- Each channel is fully independent. A stalled B channel never blocks AW, W, AR or R.

## Test plan
- Reset: rst_n=0 for 2 cycles with upstream awvalid=1 and downstream rvalid=1 → awready=0, rready=0, all downstream valids 0, idle=1. After release, awready=1.
- AW fill (depth 2), downstream awready=0: push addr 0x1000/len 3/id 5, then addr 0x2000/len 0/id 6.
  - downstream awvalid=1 one cycle after the first push, showing 0x1000 and stable; idle=0.
  - awready=0 after the second push.
  - Releasing awready → 0x1000 then 0x2000 on consecutive cycles, then idle=1.
- W stream (depth 4), wready tied 1: 16 beats back-to-back, data 0..15, wlast on beat 15 → one beat per cycle, 1-cycle latency, wlast only on data 15.
- R random backpressure (depth 8), 1000 beats with random rvalid/rready, 50% each → scoreboard exact order with no loss or duplication, and internal count never exceeds 8.
- Mixed modes, B_DEPTH=1 and AR_DEPTH=0:
  - continuous bvalid/bready → one B accepted every 2 cycles.
  - AR: araddr 0xDEAD0000 appears downstream in the same cycle, and arready mirrors downstream arready.
- Reset mid-operation: W holding 3 of 4 entries, assert rst_n for 1 cycle → downstream wvalid=0 after the edge, idle=1, and no old beat is emitted afterward.

Source files
------------

// File: rtl/armleocpu_axi_fifo_slice.sv
// armleocpu_axi_fifo_slice
// ------------------------
// AXI4 channel buffer between an AXI host (upstream) and an AXI client
// (downstream). Each of the five channels has its own buffer, sized by its
// DEPTH parameter:
//   0         -> combinational passthrough (wires only)
//   1         -> single register with a full flag (1 beat per 2 cycles)
//   2^k, k>=1 -> circular FIFO (1 beat per cycle)
// Forward channels (AW, W, AR) push from upstream and pop to downstream.
// Reverse channels (B, R) push from downstream and pop to upstream.
//
// Handshake semantics on every channel and every side: a beat transfers on a
// rising clk edge where valid and ready are both high. For buffered channels
// out_valid and in_ready come from registered state only (in_ready is also
// forced low while rst_n is low), so neither depends combinationally on the
// opposite side. A pushed beat is first visible at the output one cycle later
// (no fall-through), and the output payload is held steady while it waits.
//
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   upstream_axi_aw*/w*/ar*    requests from the host (inputs except *ready)
//   upstream_axi_b*/r*         responses to the host (outputs except *ready)
//   downstream_axi_aw*/w*/ar*  requests to the client (outputs except *ready)
//   downstream_axi_b*/r*       responses from the client (inputs except *ready)
//   idle                       high when every buffered channel is empty

// Single-channel buffer. The storage style is chosen by DEPTH; the rest of
// the slice only sees a valid/ready/data interface plus an empty flag.
module armleocpu_axi_fifo_slice_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign out_valid = in_valid;
            assign in_ready  = out_ready;
            assign out_data  = in_data;
            // A wire holds nothing, so it never holds the slice busy.
            assign empty     = 1'b1;

            logic unused_pass;
            assign unused_pass = clk ^ rst_n;
        end else if (DEPTH == 1) begin : g_reg
            logic             full_q;
            logic             full_d;
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;

            // Accept only when empty: push and pop are mutually exclusive,
            // which keeps in_ready free of any path from out_ready.
            assign in_ready  = rst_n && !full_q;
            assign out_valid = full_q;
            assign out_data  = data_q;
            assign empty     = !full_q;

            always_comb begin
                full_d = full_q;
                data_d = data_q;
                if (in_valid && in_ready) begin
                    full_d = 1'b1;
                    data_d = in_data;
                end else if (full_q && out_ready) begin
                    full_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    full_q <= 1'b0;
                end else begin
                    full_q <= full_d;
                end
            end

            // Payload storage is intentionally left out of reset.
            always_ff @(posedge clk) begin
                data_q <= data_d;
            end
        end else begin : g_fifo
            localparam int PTR_W = $clog2(DEPTH);
            localparam int CNT_W = PTR_W + 1;
            localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

            logic [WIDTH-1:0] mem_q [DEPTH];
            logic [PTR_W-1:0] wr_ptr_q;
            logic [PTR_W-1:0] wr_ptr_d;
            logic [PTR_W-1:0] rd_ptr_q;
            logic [PTR_W-1:0] rd_ptr_d;
            logic [CNT_W-1:0] count_q;
            logic [CNT_W-1:0] count_d;
            logic             push;
            logic             pop;

            assign in_ready  = rst_n && (count_q != FULL_COUNT);
            assign out_valid = (count_q != '0);
            assign out_data  = mem_q[rd_ptr_q];
            assign empty     = (count_q == '0);

            assign push = in_valid && in_ready;
            // Handshakes seen while reset is asserted are ignored.
            assign pop  = rst_n && out_valid && out_ready;

            // DEPTH is a power of two, so the pointers wrap D-1 -> 0 by
            // natural overflow of their log2(D) bits.
            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                if (push && !pop) begin
                    count_d = count_q + CNT_W'(1);
                end else if (pop && !push) begin
                    count_d = count_q - CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            // Storage is written at wr_ptr on push and never reset.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem_q[wr_ptr_q] <= in_data;
                end
            end
        end
    endgenerate

endmodule

module armleocpu_axi_fifo_slice #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int AW_DEPTH   = 2,
    parameter int W_DEPTH    = 2,
    parameter int B_DEPTH    = 2,
    parameter int AR_DEPTH   = 2,
    parameter int R_DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,

    // Upstream (host side, this module is the client)
    input  logic                    upstream_axi_awvalid,
    output logic                    upstream_axi_awready,
    input  logic [ADDR_WIDTH-1:0]   upstream_axi_awaddr,
    input  logic [7:0]              upstream_axi_awlen,
    input  logic [2:0]              upstream_axi_awsize,
    input  logic [1:0]              upstream_axi_awburst,
    input  logic                    upstream_axi_awlock,
    input  logic [ID_WIDTH-1:0]     upstream_axi_awid,
    input  logic [2:0]              upstream_axi_awprot,

    input  logic                    upstream_axi_wvalid,
    output logic                    upstream_axi_wready,
    input  logic [DATA_WIDTH-1:0]   upstream_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] upstream_axi_wstrb,
    input  logic                    upstream_axi_wlast,

    output logic                    upstream_axi_bvalid,
    input  logic                    upstream_axi_bready,
    output logic [1:0]              upstream_axi_bresp,
    output logic [ID_WIDTH-1:0]     upstream_axi_bid,

    input  logic                    upstream_axi_arvalid,
    output logic                    upstream_axi_arready,
    input  logic [ADDR_WIDTH-1:0]   upstream_axi_araddr,
    input  logic [7:0]              upstream_axi_arlen,
    input  logic [2:0]              upstream_axi_arsize,
    input  logic [1:0]              upstream_axi_arburst,
    input  logic                    upstream_axi_arlock,
    input  logic [ID_WIDTH-1:0]     upstream_axi_arid,
    input  logic [2:0]              upstream_axi_arprot,

    output logic                    upstream_axi_rvalid,
    input  logic                    upstream_axi_rready,
    output logic [1:0]              upstream_axi_rresp,
    output logic [DATA_WIDTH-1:0]   upstream_axi_rdata,
    output logic                    upstream_axi_rlast,
    output logic [ID_WIDTH-1:0]     upstream_axi_rid,

    // Downstream (client side, this module is the host)
    output logic                    downstream_axi_awvalid,
    input  logic                    downstream_axi_awready,
    output logic [ADDR_WIDTH-1:0]   downstream_axi_awaddr,
    output logic [7:0]              downstream_axi_awlen,
    output logic [2:0]              downstream_axi_awsize,
    output logic [1:0]              downstream_axi_awburst,
    output logic                    downstream_axi_awlock,
    output logic [ID_WIDTH-1:0]     downstream_axi_awid,
    output logic [2:0]              downstream_axi_awprot,

    output logic                    downstream_axi_wvalid,
    input  logic                    downstream_axi_wready,
    output logic [DATA_WIDTH-1:0]   downstream_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] downstream_axi_wstrb,
    output logic                    downstream_axi_wlast,

    input  logic                    downstream_axi_bvalid,
    output logic                    downstream_axi_bready,
    input  logic [1:0]              downstream_axi_bresp,
    input  logic [ID_WIDTH-1:0]     downstream_axi_bid,

    output logic                    downstream_axi_arvalid,
    input  logic                    downstream_axi_arready,
    output logic [ADDR_WIDTH-1:0]   downstream_axi_araddr,
    output logic [7:0]              downstream_axi_arlen,
    output logic [2:0]              downstream_axi_arsize,
    output logic [1:0]              downstream_axi_arburst,
    output logic                    downstream_axi_arlock,
    output logic [ID_WIDTH-1:0]     downstream_axi_arid,
    output logic [2:0]              downstream_axi_arprot,

    input  logic                    downstream_axi_rvalid,
    output logic                    downstream_axi_rready,
    input  logic [1:0]              downstream_axi_rresp,
    input  logic [DATA_WIDTH-1:0]   downstream_axi_rdata,
    input  logic                    downstream_axi_rlast,
    input  logic [ID_WIDTH-1:0]     downstream_axi_rid,

    output logic                    idle
);

    // Packed payload widths per channel.
    localparam int AX_W = ADDR_WIDTH + 8 + 3 + 2 + 1 + ID_WIDTH + 3;
    localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam int B_W  = ID_WIDTH + 2;
    localparam int R_W  = ID_WIDTH + 2 + DATA_WIDTH + 1;

    logic [AX_W-1:0] aw_in_data;
    logic [AX_W-1:0] aw_out_data;
    logic [W_W-1:0]  w_in_data;
    logic [W_W-1:0]  w_out_data;
    logic [B_W-1:0]  b_in_data;
    logic [B_W-1:0]  b_out_data;
    logic [AX_W-1:0] ar_in_data;
    logic [AX_W-1:0] ar_out_data;
    logic [R_W-1:0]  r_in_data;
    logic [R_W-1:0]  r_out_data;

    logic aw_empty;
    logic w_empty;
    logic b_empty;
    logic ar_empty;
    logic r_empty;

    // ---------------- AW: upstream -> downstream ----------------
    assign aw_in_data = {upstream_axi_awaddr, upstream_axi_awlen, upstream_axi_awsize,
                         upstream_axi_awburst, upstream_axi_awlock, upstream_axi_awid,
                         upstream_axi_awprot};
    assign {downstream_axi_awaddr, downstream_axi_awlen, downstream_axi_awsize,
            downstream_axi_awburst, downstream_axi_awlock, downstream_axi_awid,
            downstream_axi_awprot} = aw_out_data;

    armleocpu_axi_fifo_slice_buf #(.WIDTH(AX_W), .DEPTH(AW_DEPTH)) u_aw (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (upstream_axi_awvalid),
        .in_ready  (upstream_axi_awready),
        .in_data   (aw_in_data),
        .out_valid (downstream_axi_awvalid),
        .out_ready (downstream_axi_awready),
        .out_data  (aw_out_data),
        .empty     (aw_empty)
    );

    // ---------------- W: upstream -> downstream ----------------
    assign w_in_data = {upstream_axi_wdata, upstream_axi_wstrb, upstream_axi_wlast};
    assign {downstream_axi_wdata, downstream_axi_wstrb, downstream_axi_wlast} = w_out_data;

    armleocpu_axi_fifo_slice_buf #(.WIDTH(W_W), .DEPTH(W_DEPTH)) u_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (upstream_axi_wvalid),
        .in_ready  (upstream_axi_wready),
        .in_data   (w_in_data),
        .out_valid (downstream_axi_wvalid),
        .out_ready (downstream_axi_wready),
        .out_data  (w_out_data),
        .empty     (w_empty)
    );

    // ---------------- B: downstream -> upstream ----------------
    assign b_in_data = {downstream_axi_bid, downstream_axi_bresp};
    assign {upstream_axi_bid, upstream_axi_bresp} = b_out_data;

    armleocpu_axi_fifo_slice_buf #(.WIDTH(B_W), .DEPTH(B_DEPTH)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (downstream_axi_bvalid),
        .in_ready  (downstream_axi_bready),
        .in_data   (b_in_data),
        .out_valid (upstream_axi_bvalid),
        .out_ready (upstream_axi_bready),
        .out_data  (b_out_data),
        .empty     (b_empty)
    );

    // ---------------- AR: upstream -> downstream ----------------
    assign ar_in_data = {upstream_axi_araddr, upstream_axi_arlen, upstream_axi_arsize,
                         upstream_axi_arburst, upstream_axi_arlock, upstream_axi_arid,
                         upstream_axi_arprot};
    assign {downstream_axi_araddr, downstream_axi_arlen, downstream_axi_arsize,
            downstream_axi_arburst, downstream_axi_arlock, downstream_axi_arid,
            downstream_axi_arprot} = ar_out_data;

    armleocpu_axi_fifo_slice_buf #(.WIDTH(AX_W), .DEPTH(AR_DEPTH)) u_ar (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (upstream_axi_arvalid),
        .in_ready  (upstream_axi_arready),
        .in_data   (ar_in_data),
        .out_valid (downstream_axi_arvalid),
        .out_ready (downstream_axi_arready),
        .out_data  (ar_out_data),
        .empty     (ar_empty)
    );

    // ---------------- R: downstream -> upstream ----------------
    assign r_in_data = {downstream_axi_rid, downstream_axi_rresp, downstream_axi_rdata,
                        downstream_axi_rlast};
    assign {upstream_axi_rid, upstream_axi_rresp, upstream_axi_rdata,
            upstream_axi_rlast} = r_out_data;

    armleocpu_axi_fifo_slice_buf #(.WIDTH(R_W), .DEPTH(R_DEPTH)) u_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (downstream_axi_rvalid),
        .in_ready  (downstream_axi_rready),
        .in_data   (r_in_data),
        .out_valid (upstream_axi_rvalid),
        .out_ready (upstream_axi_rready),
        .out_data  (r_out_data),
        .empty     (r_empty)
    );

    // Built purely from registered occupancy, so it is safe for clock-gating
    // decisions; passthrough channels report empty and drop out of the AND.
    assign idle = aw_empty && w_empty && b_empty && ar_empty && r_empty;

endmodule

// File: tb/tb_armleocpu_axi_fifo_slice.sv
module tb_armleocpu_axi_fifo_slice;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 4;
    localparam int AW_DEPTH   = 2;
    localparam int W_DEPTH    = 4;
    localparam int B_DEPTH    = 1;
    localparam int AR_DEPTH   = 0;
    localparam int R_DEPTH    = 8;
    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int R_BEATS    = 1000;
    localparam int R_LIMIT    = 20000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  upstream_axi_awvalid, upstream_axi_awready;
    logic [ADDR_WIDTH-1:0] upstream_axi_awaddr;
    logic [7:0]            upstream_axi_awlen;
    logic [2:0]            upstream_axi_awsize;
    logic [1:0]            upstream_axi_awburst;
    logic                  upstream_axi_awlock;
    logic [ID_WIDTH-1:0]   upstream_axi_awid;
    logic [2:0]            upstream_axi_awprot;
    logic                  upstream_axi_wvalid, upstream_axi_wready;
    logic [DATA_WIDTH-1:0] upstream_axi_wdata;
    logic [STRB_W-1:0]     upstream_axi_wstrb;
    logic                  upstream_axi_wlast;
    logic                  upstream_axi_bvalid, upstream_axi_bready;
    logic [1:0]            upstream_axi_bresp;
    logic [ID_WIDTH-1:0]   upstream_axi_bid;
    logic                  upstream_axi_arvalid, upstream_axi_arready;
    logic [ADDR_WIDTH-1:0] upstream_axi_araddr;
    logic [7:0]            upstream_axi_arlen;
    logic [2:0]            upstream_axi_arsize;
    logic [1:0]            upstream_axi_arburst;
    logic                  upstream_axi_arlock;
    logic [ID_WIDTH-1:0]   upstream_axi_arid;
    logic [2:0]            upstream_axi_arprot;
    logic                  upstream_axi_rvalid, upstream_axi_rready;
    logic [1:0]            upstream_axi_rresp;
    logic [DATA_WIDTH-1:0] upstream_axi_rdata;
    logic                  upstream_axi_rlast;
    logic [ID_WIDTH-1:0]   upstream_axi_rid;

    logic                  downstream_axi_awvalid, downstream_axi_awready;
    logic [ADDR_WIDTH-1:0] downstream_axi_awaddr;
    logic [7:0]            downstream_axi_awlen;
    logic [2:0]            downstream_axi_awsize;
    logic [1:0]            downstream_axi_awburst;
    logic                  downstream_axi_awlock;
    logic [ID_WIDTH-1:0]   downstream_axi_awid;
    logic [2:0]            downstream_axi_awprot;
    logic                  downstream_axi_wvalid, downstream_axi_wready;
    logic [DATA_WIDTH-1:0] downstream_axi_wdata;
    logic [STRB_W-1:0]     downstream_axi_wstrb;
    logic                  downstream_axi_wlast;
    logic                  downstream_axi_bvalid, downstream_axi_bready;
    logic [1:0]            downstream_axi_bresp;
    logic [ID_WIDTH-1:0]   downstream_axi_bid;
    logic                  downstream_axi_arvalid, downstream_axi_arready;
    logic [ADDR_WIDTH-1:0] downstream_axi_araddr;
    logic [7:0]            downstream_axi_arlen;
    logic [2:0]            downstream_axi_arsize;
    logic [1:0]            downstream_axi_arburst;
    logic                  downstream_axi_arlock;
    logic [ID_WIDTH-1:0]   downstream_axi_arid;
    logic [2:0]            downstream_axi_arprot;
    logic                  downstream_axi_rvalid, downstream_axi_rready;
    logic [1:0]            downstream_axi_rresp;
    logic [DATA_WIDTH-1:0] downstream_axi_rdata;
    logic                  downstream_axi_rlast;
    logic [ID_WIDTH-1:0]   downstream_axi_rid;
    logic                  idle;

    armleocpu_axi_fifo_slice #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH),
        .AW_DEPTH(AW_DEPTH), .W_DEPTH(W_DEPTH), .B_DEPTH(B_DEPTH),
        .AR_DEPTH(AR_DEPTH), .R_DEPTH(R_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .upstream_axi_awvalid(upstream_axi_awvalid), .upstream_axi_awready(upstream_axi_awready),
        .upstream_axi_awaddr(upstream_axi_awaddr), .upstream_axi_awlen(upstream_axi_awlen),
        .upstream_axi_awsize(upstream_axi_awsize), .upstream_axi_awburst(upstream_axi_awburst),
        .upstream_axi_awlock(upstream_axi_awlock), .upstream_axi_awid(upstream_axi_awid),
        .upstream_axi_awprot(upstream_axi_awprot),
        .upstream_axi_wvalid(upstream_axi_wvalid), .upstream_axi_wready(upstream_axi_wready),
        .upstream_axi_wdata(upstream_axi_wdata), .upstream_axi_wstrb(upstream_axi_wstrb),
        .upstream_axi_wlast(upstream_axi_wlast),
        .upstream_axi_bvalid(upstream_axi_bvalid), .upstream_axi_bready(upstream_axi_bready),
        .upstream_axi_bresp(upstream_axi_bresp), .upstream_axi_bid(upstream_axi_bid),
        .upstream_axi_arvalid(upstream_axi_arvalid), .upstream_axi_arready(upstream_axi_arready),
        .upstream_axi_araddr(upstream_axi_araddr), .upstream_axi_arlen(upstream_axi_arlen),
        .upstream_axi_arsize(upstream_axi_arsize), .upstream_axi_arburst(upstream_axi_arburst),
        .upstream_axi_arlock(upstream_axi_arlock), .upstream_axi_arid(upstream_axi_arid),
        .upstream_axi_arprot(upstream_axi_arprot),
        .upstream_axi_rvalid(upstream_axi_rvalid), .upstream_axi_rready(upstream_axi_rready),
        .upstream_axi_rresp(upstream_axi_rresp), .upstream_axi_rdata(upstream_axi_rdata),
        .upstream_axi_rlast(upstream_axi_rlast), .upstream_axi_rid(upstream_axi_rid),
        .downstream_axi_awvalid(downstream_axi_awvalid), .downstream_axi_awready(downstream_axi_awready),
        .downstream_axi_awaddr(downstream_axi_awaddr), .downstream_axi_awlen(downstream_axi_awlen),
        .downstream_axi_awsize(downstream_axi_awsize), .downstream_axi_awburst(downstream_axi_awburst),
        .downstream_axi_awlock(downstream_axi_awlock), .downstream_axi_awid(downstream_axi_awid),
        .downstream_axi_awprot(downstream_axi_awprot),
        .downstream_axi_wvalid(downstream_axi_wvalid), .downstream_axi_wready(downstream_axi_wready),
        .downstream_axi_wdata(downstream_axi_wdata), .downstream_axi_wstrb(downstream_axi_wstrb),
        .downstream_axi_wlast(downstream_axi_wlast),
        .downstream_axi_bvalid(downstream_axi_bvalid), .downstream_axi_bready(downstream_axi_bready),
        .downstream_axi_bresp(downstream_axi_bresp), .downstream_axi_bid(downstream_axi_bid),
        .downstream_axi_arvalid(downstream_axi_arvalid), .downstream_axi_arready(downstream_axi_arready),
        .downstream_axi_araddr(downstream_axi_araddr), .downstream_axi_arlen(downstream_axi_arlen),
        .downstream_axi_arsize(downstream_axi_arsize), .downstream_axi_arburst(downstream_axi_arburst),
        .downstream_axi_arlock(downstream_axi_arlock), .downstream_axi_arid(downstream_axi_arid),
        .downstream_axi_arprot(downstream_axi_arprot),
        .downstream_axi_rvalid(downstream_axi_rvalid), .downstream_axi_rready(downstream_axi_rready),
        .downstream_axi_rresp(downstream_axi_rresp), .downstream_axi_rdata(downstream_axi_rdata),
        .downstream_axi_rlast(downstream_axi_rlast), .downstream_axi_rid(downstream_axi_rid),
        .idle(idle)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [63:0] aw_exp_q[$];
    logic [63:0] w_exp_q[$];
    logic [63:0] b_exp_q[$];
    logic [63:0] ar_exp_q[$];
    logic [63:0] r_exp_q[$];
    int aw_pops = 0;
    int w_pops = 0;
    int r_pops = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change just after posedge; everything is observed on negedge,
    // where each queue's size equals the channel's registered occupancy.
    always @(negedge clk) begin
        if (!rst_n) begin
            aw_exp_q.delete();
            w_exp_q.delete();
            b_exp_q.delete();
            ar_exp_q.delete();
            r_exp_q.delete();
        end else begin
            check_eq("aw_out_valid", 64'(downstream_axi_awvalid), 64'(aw_exp_q.size() != 0));
            check_eq("aw_in_ready", 64'(upstream_axi_awready), 64'(aw_exp_q.size() != AW_DEPTH));
            check_eq("w_out_valid", 64'(downstream_axi_wvalid), 64'(w_exp_q.size() != 0));
            check_eq("w_in_ready", 64'(upstream_axi_wready), 64'(w_exp_q.size() != W_DEPTH));
            check_eq("b_out_valid", 64'(upstream_axi_bvalid), 64'(b_exp_q.size() != 0));
            check_eq("b_in_ready", 64'(downstream_axi_bready), 64'(b_exp_q.size() != B_DEPTH));
            check_eq("r_out_valid", 64'(upstream_axi_rvalid), 64'(r_exp_q.size() != 0));
            check_eq("r_in_ready", 64'(downstream_axi_rready), 64'(r_exp_q.size() != R_DEPTH));
            check_eq("r_max_count", 64'(r_exp_q.size() <= R_DEPTH), 64'd1);
            check_eq("ar_valid_pass", 64'(downstream_axi_arvalid), 64'(upstream_axi_arvalid));
            check_eq("ar_ready_pass", 64'(upstream_axi_arready), 64'(downstream_axi_arready));
            check_eq("idle", 64'(idle), 64'(aw_exp_q.size() == 0 && w_exp_q.size() == 0 &&
                                            b_exp_q.size() == 0 && r_exp_q.size() == 0));

            // Buffered channels: pop before push so a same-cycle push can
            // never satisfy a pop (no fall-through allowed).
            if (downstream_axi_awvalid && downstream_axi_awready) begin
                aw_pops++;
                if (aw_exp_q.size() == 0) check_eq("aw_pop_empty", 64'(aw_exp_q.size()), 64'd1);
                else check_eq("aw_payload", 64'({downstream_axi_awaddr, downstream_axi_awlen,
                    downstream_axi_awsize, downstream_axi_awburst, downstream_axi_awlock,
                    downstream_axi_awid, downstream_axi_awprot}), aw_exp_q.pop_front());
            end
            if (downstream_axi_wvalid && downstream_axi_wready) begin
                w_pops++;
                if (w_exp_q.size() == 0) check_eq("w_pop_empty", 64'(w_exp_q.size()), 64'd1);
                else check_eq("w_payload", 64'({downstream_axi_wdata, downstream_axi_wstrb,
                    downstream_axi_wlast}), w_exp_q.pop_front());
            end
            if (upstream_axi_bvalid && upstream_axi_bready) begin
                if (b_exp_q.size() == 0) check_eq("b_pop_empty", 64'(b_exp_q.size()), 64'd1);
                else check_eq("b_payload", 64'({upstream_axi_bid, upstream_axi_bresp}),
                              b_exp_q.pop_front());
            end
            if (upstream_axi_rvalid && upstream_axi_rready) begin
                r_pops++;
                if (r_exp_q.size() == 0) check_eq("r_pop_empty", 64'(r_exp_q.size()), 64'd1);
                else check_eq("r_payload", 64'({upstream_axi_rid, upstream_axi_rresp,
                    upstream_axi_rdata, upstream_axi_rlast}), r_exp_q.pop_front());
            end

            if (upstream_axi_awvalid && upstream_axi_awready)
                aw_exp_q.push_back(64'({upstream_axi_awaddr, upstream_axi_awlen,
                    upstream_axi_awsize, upstream_axi_awburst, upstream_axi_awlock,
                    upstream_axi_awid, upstream_axi_awprot}));
            if (upstream_axi_wvalid && upstream_axi_wready)
                w_exp_q.push_back(64'({upstream_axi_wdata, upstream_axi_wstrb, upstream_axi_wlast}));
            if (downstream_axi_bvalid && downstream_axi_bready)
                b_exp_q.push_back(64'({downstream_axi_bid, downstream_axi_bresp}));
            if (downstream_axi_rvalid && downstream_axi_rready)
                r_exp_q.push_back(64'({downstream_axi_rid, downstream_axi_rresp,
                    downstream_axi_rdata, downstream_axi_rlast}));

            // Passthrough AR: the same beat enters and leaves in one cycle.
            if (upstream_axi_arvalid && upstream_axi_arready)
                ar_exp_q.push_back(64'({upstream_axi_araddr, upstream_axi_arlen,
                    upstream_axi_arsize, upstream_axi_arburst, upstream_axi_arlock,
                    upstream_axi_arid, upstream_axi_arprot}));
            if (downstream_axi_arvalid && downstream_axi_arready) begin
                if (ar_exp_q.size() == 0) check_eq("ar_pop_empty", 64'(ar_exp_q.size()), 64'd1);
                else check_eq("ar_payload", 64'({downstream_axi_araddr, downstream_axi_arlen,
                    downstream_axi_arsize, downstream_axi_arburst, downstream_axi_arlock,
                    downstream_axi_arid, downstream_axi_arprot}), ar_exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_aw(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
        upstream_axi_awvalid = 1'b1;
        upstream_axi_awaddr  = addr;
        upstream_axi_awlen   = len;
        upstream_axi_awsize  = 3'($urandom_range(0, 7));
        upstream_axi_awburst = 2'($urandom_range(0, 3));
        upstream_axi_awlock  = 1'($urandom_range(0, 1));
        upstream_axi_awid    = id;
        upstream_axi_awprot  = 3'($urandom_range(0, 7));
    endtask

    task automatic drive_w(input logic [31:0] data, input logic last);
        upstream_axi_wvalid = 1'b1;
        upstream_axi_wdata  = data;
        upstream_axi_wstrb  = STRB_W'($urandom_range(0, 15));
        upstream_axi_wlast  = last;
    endtask

    task automatic init_inputs();
        {upstream_axi_awvalid, upstream_axi_awaddr, upstream_axi_awlen, upstream_axi_awsize,
         upstream_axi_awburst, upstream_axi_awlock, upstream_axi_awid, upstream_axi_awprot} = '0;
        {upstream_axi_wvalid, upstream_axi_wdata, upstream_axi_wstrb, upstream_axi_wlast} = '0;
        upstream_axi_bready = 1'b0;
        {upstream_axi_arvalid, upstream_axi_araddr, upstream_axi_arlen, upstream_axi_arsize,
         upstream_axi_arburst, upstream_axi_arlock, upstream_axi_arid, upstream_axi_arprot} = '0;
        upstream_axi_rready = 1'b0;
        downstream_axi_awready = 1'b0;
        downstream_axi_wready  = 1'b0;
        {downstream_axi_bvalid, downstream_axi_bresp, downstream_axi_bid} = '0;
        downstream_axi_arready = 1'b0;
        {downstream_axi_rvalid, downstream_axi_rresp, downstream_axi_rdata,
         downstream_axi_rlast, downstream_axi_rid} = '0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] b_next;
        int b_acc;
        int r_sent;
        int cyc;
        logic rv;

        init_inputs();
        rst_n = 1'b0;
        upstream_axi_awvalid  = 1'b1;
        downstream_axi_rvalid = 1'b1;

        // Reset held for two cycles with valids asserted on both sides.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_awready", 64'(upstream_axi_awready), 64'd0);
        check_eq("rst_rready", 64'(downstream_axi_rready), 64'd0);
        check_eq("rst_down_awvalid", 64'(downstream_axi_awvalid), 64'd0);
        check_eq("rst_down_wvalid", 64'(downstream_axi_wvalid), 64'd0);
        check_eq("rst_down_arvalid", 64'(downstream_axi_arvalid), 64'd0);
        check_eq("rst_up_bvalid", 64'(upstream_axi_bvalid), 64'd0);
        check_eq("rst_up_rvalid", 64'(upstream_axi_rvalid), 64'd0);
        check_eq("rst_idle", 64'(idle), 64'd1);
        next_cycle();
        rst_n = 1'b1;
        upstream_axi_awvalid  = 1'b0;
        downstream_axi_rvalid = 1'b0;
        @(negedge clk);
        check_eq("rel_awready", 64'(upstream_axi_awready), 64'd1);
        check_eq("rel_wready", 64'(upstream_axi_wready), 64'd1);
        check_eq("rel_idle", 64'(idle), 64'd1);

        // AW fill with downstream stalled.
        next_cycle();
        drive_aw(32'h0000_1000, 8'd3, 4'd5);
        @(negedge clk);
        check_eq("aw_first_ready", 64'(upstream_axi_awready), 64'd1);
        next_cycle();
        drive_aw(32'h0000_2000, 8'd0, 4'd6);
        @(negedge clk);
        check_eq("aw_first_visible", 64'(downstream_axi_awvalid), 64'd1);
        check_eq("aw_first_addr", 64'(downstream_axi_awaddr), 64'h1000);
        check_eq("aw_first_len", 64'(downstream_axi_awlen), 64'd3);
        check_eq("aw_first_id", 64'(downstream_axi_awid), 64'd5);
        check_eq("aw_busy_idle", 64'(idle), 64'd0);
        next_cycle();
        upstream_axi_awvalid = 1'b0;
        @(negedge clk);
        check_eq("aw_full_ready", 64'(upstream_axi_awready), 64'd0);
        check_eq("aw_stall_addr", 64'(downstream_axi_awaddr), 64'h1000);
        next_cycle();
        @(negedge clk);
        check_eq("aw_stall_addr2", 64'(downstream_axi_awaddr), 64'h1000);
        next_cycle();
        downstream_axi_awready = 1'b1;
        @(negedge clk);
        check_eq("aw_drain0_addr", 64'(downstream_axi_awaddr), 64'h1000);
        next_cycle();
        @(negedge clk);
        check_eq("aw_drain1_valid", 64'(downstream_axi_awvalid), 64'd1);
        check_eq("aw_drain1_addr", 64'(downstream_axi_awaddr), 64'h2000);
        check_eq("aw_drain1_id", 64'(downstream_axi_awid), 64'd6);
        next_cycle();
        @(negedge clk);
        check_eq("aw_drained_valid", 64'(downstream_axi_awvalid), 64'd0);
        check_eq("aw_drained_idle", 64'(idle), 64'd1);
        check_eq("aw_pop_count", 64'(aw_pops), 64'd2);
        downstream_axi_awready = 1'b0;

        // W stream: 16 back-to-back beats into a depth-4 FIFO.
        downstream_axi_wready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            drive_w(32'(i), i == 15);
            @(negedge clk);
            check_eq("w_stream_ready", 64'(upstream_axi_wready), 64'd1);
            if (i > 0) begin
                check_eq("w_stream_valid", 64'(downstream_axi_wvalid), 64'd1);
                check_eq("w_stream_latency", 64'(downstream_axi_wdata), 64'(i - 1));
                check_eq("w_stream_last", 64'(downstream_axi_wlast), 64'd0);
            end
        end
        next_cycle();
        upstream_axi_wvalid = 1'b0;
        upstream_axi_wlast  = 1'b0;
        @(negedge clk);
        check_eq("w_final_data", 64'(downstream_axi_wdata), 64'd15);
        check_eq("w_final_last", 64'(downstream_axi_wlast), 64'd1);
        next_cycle();
        @(negedge clk);
        check_eq("w_drained", 64'(downstream_axi_wvalid), 64'd0);
        check_eq("w_pop_count", 64'(w_pops), 64'd16);

        // B through a single register: one acceptance every other cycle.
        upstream_axi_bready = 1'b1;
        b_next = 4'd0;
        b_acc = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            downstream_axi_bvalid = 1'b1;
            downstream_axi_bid    = b_next;
            downstream_axi_bresp  = b_next[1:0];
            @(negedge clk);
            check_eq("b_alternate", 64'(downstream_axi_bready), 64'(c % 2 == 0));
            #1;
            if (downstream_axi_bready) begin
                b_acc++;
                b_next = b_next + 4'd1;
            end
        end
        next_cycle();
        downstream_axi_bvalid = 1'b0;
        check_eq("b_rate", 64'(b_acc), 64'd10);

        // AR passthrough is purely combinational.
        next_cycle();
        upstream_axi_arvalid = 1'b1;
        upstream_axi_araddr  = 32'hDEAD_0000;
        upstream_axi_arlen   = 8'd7;
        upstream_axi_arid    = 4'd3;
        @(negedge clk);
        check_eq("ar_same_cycle_valid", 64'(downstream_axi_arvalid), 64'd1);
        check_eq("ar_same_cycle_addr", 64'(downstream_axi_araddr), 64'hDEAD_0000);
        check_eq("ar_ready_low", 64'(upstream_axi_arready), 64'd0);
        next_cycle();
        downstream_axi_arready = 1'b1;
        @(negedge clk);
        check_eq("ar_ready_high", 64'(upstream_axi_arready), 64'd1);
        next_cycle();
        upstream_axi_arvalid   = 1'b0;
        downstream_axi_arready = 1'b0;

        // R with random valid and ready on both sides.
        r_sent = 0;
        cyc = 0;
        rv = 1'b0;
        while ((r_sent < R_BEATS || r_exp_q.size() != 0) && cyc < R_LIMIT) begin
            next_cycle();
            if (!rv && r_sent < R_BEATS && $urandom_range(0, 1) == 1) begin
                rv = 1'b1;
                downstream_axi_rdata = $urandom;
                downstream_axi_rid   = 4'($urandom_range(0, 15));
                downstream_axi_rresp = 2'($urandom_range(0, 3));
                downstream_axi_rlast = (r_sent % 4 == 3);
            end
            downstream_axi_rvalid = rv;
            upstream_axi_rready   = 1'($urandom_range(0, 1));
            @(negedge clk);
            #1;
            if (rv && downstream_axi_rready) begin
                rv = 1'b0;
                r_sent++;
            end
            cyc++;
        end
        check_eq("r_no_timeout", 64'(cyc < R_LIMIT), 64'd1);
        check_eq("r_pop_count", 64'(r_pops), 64'(R_BEATS));
        next_cycle();
        downstream_axi_rvalid = 1'b0;
        upstream_axi_rready   = 1'b0;

        // Reset with three W beats held, then confirm nothing old escapes.
        downstream_axi_wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive_w(32'hA0 + 32'(i), 1'b0);
            @(negedge clk);
            check_eq("mr_fill_ready", 64'(upstream_axi_wready), 64'd1);
        end
        next_cycle();
        upstream_axi_wvalid = 1'b0;
        @(negedge clk);
        check_eq("mr_held_valid", 64'(downstream_axi_wvalid), 64'd1);
        check_eq("mr_held_idle", 64'(idle), 64'd0);
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mr_wvalid", 64'(downstream_axi_wvalid), 64'd0);
        check_eq("mr_idle", 64'(idle), 64'd1);
        check_eq("mr_wready", 64'(upstream_axi_wready), 64'd1);
        next_cycle();
        downstream_axi_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("mr_no_old_beat", 64'(downstream_axi_wvalid), 64'd0);
        end
        check_eq("mr_w_pops", 64'(w_pops), 64'd16);

        check_eq("end_queues_empty", 64'(aw_exp_q.size() + w_exp_q.size() + b_exp_q.size() +
                                          ar_exp_q.size() + r_exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
